// File: rtl/fetch_pkg.sv
// Shared constants and the queue-entry record for the instruction fetch unit.
package fetch_pkg;

  localparam int unsigned DefAddrW  = 32;
  localparam int unsigned DefDataW  = 32;
  localparam int unsigned DefQDepth = 4;
  localparam logic [DefAddrW-1:0] DefResetPc = '0;

  typedef struct packed {
    logic [DefDataW-1:0] instr;
    logic [DefAddrW-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_if.sv
// Fetch unit bus: instruction-memory request side plus decode-facing output queue.
interface fetch_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned QDEPTH = 4
) ();
  localparam int unsigned CntW = $clog2(QDEPTH) + 1;

  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_rdata;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_instr;
  logic [ADDR_W-1:0] out_pc;
  logic [ADDR_W-1:0] out_pc_plus4;
  logic [CntW-1:0]   q_count;

  modport master (
    output imem_req, imem_addr, out_valid, out_instr, out_pc, out_pc_plus4, q_count,
    input  imem_rdata, redirect_valid, redirect_pc, out_ready
  );

  modport slave (
    input  imem_req, imem_addr, out_valid, out_instr, out_pc, out_pc_plus4, q_count,
    output imem_rdata, redirect_valid, redirect_pc, out_ready
  );
endinterface

// File: rtl/fetch_queue.sv
// Synchronous power-of-two FIFO with flush; push to a full queue is accepted only
// when a pop frees the head in the same cycle.
module fetch_queue import fetch_pkg::*; #(
  parameter type         entry_t = fetch_entry_t,
  parameter int unsigned Depth   = DefQDepth
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  entry_t                 data_i,
  input  logic                   pop_i,
  output entry_t                 data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(Depth):0] count_o
);
  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  entry_t            mem_q [Depth];
  logic [PtrW-1:0]   wr_ptr_d, wr_ptr_q;
  logic [PtrW-1:0]   rd_ptr_d, rd_ptr_q;
  logic [CntW-1:0]   count_d, count_q;
  logic              do_push, do_pop;

  always_comb begin
    empty_o = (count_q == '0);
    full_o  = (count_q == CntW'(Depth));
    do_pop  = pop_i & ~empty_o;
    do_push = push_i & (~full_o | do_pop);
    // Pointers wrap naturally because Depth is a power of two.
    wr_ptr_d = wr_ptr_q + PtrW'(do_push);
    rd_ptr_d = rd_ptr_q + PtrW'(do_pop);
    count_d  = count_q + CntW'(do_push) - CntW'(do_pop);
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
    data_o  = mem_q[rd_ptr_q];
    count_o = count_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: credit-limited sequential fetch into a small queue, with
// redirect flush and one-cycle memory latency tracking.
module fetch_unit import fetch_pkg::*; #(
  parameter int unsigned       ADDR_W   = DefAddrW,
  parameter int unsigned       DATA_W   = DefDataW,
  parameter int unsigned       QDEPTH   = DefQDepth,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DefResetPc)
) (
  input logic     clk,
  input logic     rst,
  fetch_if.master bus
);
  localparam int unsigned CntW = $clog2(QDEPTH) + 1;

  if ((QDEPTH < 2) || ((QDEPTH & (QDEPTH - 1)) != 0)) begin : g_bad_depth
    $error("fetch_unit: QDEPTH must be a power of two and at least 2");
  end

  typedef struct packed {
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] pc;
  } entry_t;

  logic [ADDR_W-1:0] fetch_pc_d, fetch_pc_q;
  logic [ADDR_W-1:0] inflight_pc_d, inflight_pc_q;
  logic              inflight_d, inflight_q;
  logic [CntW-1:0]   count, used;
  logic              empty, queue_full_unused;
  logic              req, push, pop, valid;
  entry_t            head, push_entry;

  // A request is only issued if its response is guaranteed a free slot.
  always_comb begin
    used       = count + CntW'(inflight_q);
    req        = ~rst & ~bus.redirect_valid & (used < CntW'(QDEPTH));
    push       = inflight_q & ~bus.redirect_valid & ~rst;
    valid      = ~rst & ~empty;
    pop        = valid & bus.out_ready;
    push_entry = '{instr: bus.imem_rdata, pc: inflight_pc_q};
  end

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_d    = req;
    inflight_pc_d = fetch_pc_q;
    if (bus.redirect_valid) begin
      fetch_pc_d = bus.redirect_pc & ~ADDR_W'(3);
    end else if (req) begin
      fetch_pc_d = fetch_pc_q + ADDR_W'(4);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  fetch_queue #(
    .entry_t (entry_t),
    .Depth   (QDEPTH)
  ) u_queue (
    .clk     (clk),
    .rst     (rst),
    .flush_i (bus.redirect_valid),
    .push_i  (push),
    .data_i  (push_entry),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (queue_full_unused),
    .empty_o (empty),
    .count_o (count)
  );

  always_comb begin
    bus.imem_req     = req;
    bus.imem_addr    = rst ? RESET_PC : fetch_pc_q;
    bus.out_valid    = valid;
    bus.out_instr    = rst ? '0 : head.instr;
    bus.out_pc       = rst ? '0 : head.pc;
    bus.out_pc_plus4 = rst ? '0 : head.pc + ADDR_W'(4);
    bus.q_count      = rst ? '0 : count;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed phases push expected outputs, monitors
// pop and compare on every output handshake.
module tb_fetch_unit;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] plus4;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  exp_t exp_q[$];
  exp_t exp8_q[$];
  exp_t e_main;
  exp_t e_8;
  logic req_prev;

  fetch_if #(.ADDR_W(32), .DATA_W(32), .QDEPTH(4)) bus ();
  fetch_if #(.ADDR_W(8),  .DATA_W(32), .QDEPTH(4)) bus8 ();

  fetch_unit #(.ADDR_W(32), .DATA_W(32), .QDEPTH(4), .RESET_PC(32'h0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  fetch_unit #(.ADDR_W(8), .DATA_W(32), .QDEPTH(4), .RESET_PC(8'h0)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: word returned one cycle after the request equals its address.
  always @(posedge clk) begin
    if (bus.imem_req) bus.imem_rdata <= bus.imem_addr;
    if (bus8.imem_req) bus8.imem_rdata <= 32'(bus8.imem_addr);
    req_prev <= bus.imem_req;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] pc);
    exp_q.push_back('{pc: pc, instr: pc, plus4: pc + 32'd4});
  endtask

  task automatic push_exp8(input logic [7:0] pc);
    logic [7:0] p4;
    p4 = pc + 8'd4;
    exp8_q.push_back('{pc: 32'(pc), instr: 32'(pc), plus4: 32'(p4)});
  endtask

  task automatic drained(input string name, input int n);
    chk(name, 32'(n), 32'd0);
  endtask

  // Main scoreboard monitor, plus detection of a response landing on a full queue.
  always @(negedge clk) begin
    if (bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_unexpected: got pc %h, want no output", bus.out_pc);
      end else begin
        e_main = exp_q.pop_front();
        chk("out_pc", bus.out_pc, e_main.pc);
        chk("out_instr", bus.out_instr, e_main.instr);
        chk("out_pc_plus4", bus.out_pc_plus4, e_main.plus4);
      end
    end
    if (req_prev && !bus.redirect_valid && !rst) begin
      checks++;
      if (bus.q_count == 3'd4 && !(bus.out_valid && bus.out_ready)) begin
        errors++;
        $display("FAIL push_full: got push with q_count %0d, want q_count < 4", bus.q_count);
      end
    end
  end

  always @(negedge clk) begin
    if (bus8.out_valid && bus8.out_ready) begin
      if (exp8_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop8_unexpected: got pc %h, want no output", bus8.out_pc);
      end else begin
        e_8 = exp8_q.pop_front();
        chk("out8_pc", 32'(bus8.out_pc), e_8.pc);
        chk("out8_instr", bus8.out_instr, e_8.instr);
        chk("out8_pc_plus4", 32'(bus8.out_pc_plus4), e_8.plus4);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  // Leaves the caller in the first cycle after reset release.
  task automatic do_reset(input logic rdy);
    tick();
    rst = 1'b1;
    bus.out_ready = rdy;
    bus.redirect_valid = 1'b0;
    bus8.out_ready = 1'b0;
    bus8.redirect_valid = 1'b0;
    tick();
    neg();
    chk("rst_out_valid", bus.out_valid, 32'd0);
    chk("rst_q_count", bus.q_count, 32'd0);
    chk("rst_imem_req", bus.imem_req, 32'd0);
    chk("rst_imem_addr", bus.imem_addr, 32'd0);
    chk("rst_out_pc", bus.out_pc, 32'd0);
    chk("rst_out_instr", bus.out_instr, 32'd0);
    chk("rst_out_pc_plus4", bus.out_pc_plus4, 32'd0);
    tick();
    rst = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.out_ready = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0;
    bus8.out_ready = 1'b0;
    bus8.redirect_valid = 1'b0;
    bus8.redirect_pc = '0;

    // Stream: 8 words on consecutive cycles starting 2 cycles after release.
    do_reset(1'b1);
    for (int i = 0; i < 8; i++) push_exp(32'(4 * i));
    neg();
    chk("a_first_req", bus.imem_req, 32'd1);
    chk("a_first_addr", bus.imem_addr, 32'd0);
    run(1);
    neg();
    chk("a_latency_valid", bus.out_valid, 32'd0);
    run(9);
    bus.out_ready = 1'b0;
    drained("a_drained", exp_q.size());

    // Backpressure: queue saturates at 4, request stops, head holds.
    do_reset(1'b0);
    run(5);
    neg();
    chk("b_q_full", bus.q_count, 32'd4);
    chk("b_hold_pc_c5", bus.out_pc, 32'd0);
    run(4);
    neg();
    chk("b_q_count", bus.q_count, 32'd4);
    chk("b_req_off", bus.imem_req, 32'd0);
    chk("b_hold_valid", bus.out_valid, 32'd1);
    chk("b_hold_pc", bus.out_pc, 32'd0);
    chk("b_hold_plus4", bus.out_pc_plus4, 32'd4);
    for (int i = 0; i < 4; i++) push_exp(32'(4 * i));
    run(1);
    bus.out_ready = 1'b1;
    run(4);
    bus.out_ready = 1'b0;
    drained("b_drained", exp_q.size());
    neg();
    chk("b_next_head", bus.out_pc, 32'h10);
    chk("b_next_count", bus.q_count, 32'd2);

    // Redirect to 0x103 while the 0x4 response is in flight; head 0x0 pops alongside.
    do_reset(1'b1);
    push_exp(32'h0);
    push_exp(32'h100);
    push_exp(32'h104);
    push_exp(32'h108);
    run(2);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h103;
    neg();
    chk("c_req_during_redirect", bus.imem_req, 32'd0);
    run(1);
    bus.redirect_valid = 1'b0;
    neg();
    chk("c_flushed_valid", bus.out_valid, 32'd0);
    chk("c_flushed_count", bus.q_count, 32'd0);
    chk("c_target_req", bus.imem_req, 32'd1);
    chk("c_target_addr", bus.imem_addr, 32'h100);
    run(5);
    bus.out_ready = 1'b0;
    drained("c_drained", exp_q.size());

    // Redirect coinciding with a pop while full.
    do_reset(1'b0);
    run(5);
    neg();
    chk("d_full", bus.q_count, 32'd4);
    run(1);
    bus.out_ready = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h200;
    push_exp(32'h0);
    push_exp(32'h200);
    push_exp(32'h204);
    run(1);
    bus.redirect_valid = 1'b0;
    neg();
    chk("d_count_zero", bus.q_count, 32'd0);
    chk("d_valid_zero", bus.out_valid, 32'd0);
    chk("d_resume_req", bus.imem_req, 32'd1);
    chk("d_resume_addr", bus.imem_addr, 32'h200);
    run(4);
    bus.out_ready = 1'b0;
    drained("d_drained", exp_q.size());

    // Back-to-back redirects: only the 0x400 stream may appear.
    do_reset(1'b1);
    run(1);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h300;
    run(1);
    bus.redirect_pc = 32'h400;
    run(1);
    bus.redirect_valid = 1'b0;
    neg();
    chk("e_last_wins_addr", bus.imem_addr, 32'h400);
    chk("e_last_wins_req", bus.imem_req, 32'd1);
    chk("e_no_stale_valid", bus.out_valid, 32'd0);
    push_exp(32'h400);
    push_exp(32'h404);
    run(4);
    bus.out_ready = 1'b0;
    drained("e_drained", exp_q.size());

    // Mid-stream reset with 3 entries queued.
    do_reset(1'b0);
    run(4);
    chk("f_three_queued", bus.q_count, 32'd3);
    rst = 1'b1;
    neg();
    chk("f_rst_valid", bus.out_valid, 32'd0);
    run(1);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    neg();
    chk("f_after_valid", bus.out_valid, 32'd0);
    chk("f_after_count", bus.q_count, 32'd0);
    chk("f_restart_req", bus.imem_req, 32'd1);
    chk("f_restart_addr", bus.imem_addr, 32'h0);
    push_exp(32'h0);
    push_exp(32'h4);
    run(4);
    bus.out_ready = 1'b0;
    drained("f_drained", exp_q.size());

    // 8-bit address wrap-around after redirect to 0xF8.
    do_reset(1'b0);
    bus8.redirect_valid = 1'b1;
    bus8.redirect_pc = 8'hF8;
    bus8.out_ready = 1'b1;
    push_exp8(8'hF8);
    push_exp8(8'hFC);
    push_exp8(8'h00);
    push_exp8(8'h04);
    neg();
    chk("g_req_during_redirect", bus8.imem_req, 32'd0);
    run(1);
    bus8.redirect_valid = 1'b0;
    neg();
    chk("g_first_addr", 32'(bus8.imem_addr), 32'hF8);
    run(3);
    neg();
    chk("g_pc_fc", 32'(bus8.out_pc), 32'hFC);
    chk("g_plus4_wrap", 32'(bus8.out_pc_plus4), 32'h00);
    run(3);
    bus8.out_ready = 1'b0;
    drained("g_drained", exp8_q.size());

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want bench completion");
    $fatal(1, "watchdog expired");
  end

endmodule
